// File: rtl/rns_mac_32_17_13_11.sv
// Residue-domain multiply-accumulate over moduli (32,17,13,11): a three-stage per-channel
// pipeline (product, reduce, accumulate) with a burst FSM and a valid/ready result port.
module rns_mac_32_17_13_11 #(
   parameter int unsigned MOD_1     = 32,
   parameter int unsigned MOD_1_K   = 5,
   parameter int unsigned MOD_2     = 17,
   parameter int unsigned MOD_3     = 13,
   parameter int unsigned MOD_4     = 11,
   parameter int unsigned MAX_MOD   = 5,
   parameter int unsigned MAX_TERMS = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [MAX_MOD-1:0] a0,
   input  logic [MAX_MOD-1:0] a1,
   input  logic [MAX_MOD-1:0] a2,
   input  logic [MAX_MOD-1:0] a3,
   input  logic [MAX_MOD-1:0] b0,
   input  logic [MAX_MOD-1:0] b1,
   input  logic [MAX_MOD-1:0] b2,
   input  logic [MAX_MOD-1:0] b3,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output logic [MAX_MOD-1:0] y0,
   output logic [MAX_MOD-1:0] y1,
   output logic [MAX_MOD-1:0] y2,
   output logic [MAX_MOD-1:0] y3,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               err
);

   localparam int unsigned PW = 2 * MAX_MOD;

   typedef enum logic [1:0] {StAcc, StDrain, StHold} state_e;

   state_e             r_state, w_state_d;
   logic [MAX_MOD-1:0] w_a   [4];
   logic [MAX_MOD-1:0] w_b   [4];
   logic [MAX_MOD-1:0] w_acc [4];
   logic [3:0]         w_oor;
   logic               r_v1, r_v2, r_l1, r_l2, r_err;
   logic [7:0]         r_cnt;
   logic               w_accept, w_last, w_done, w_clear;

   assign w_a[0] = a0;
   assign w_a[1] = a1;
   assign w_a[2] = a2;
   assign w_a[3] = a3;
   assign w_b[0] = b0;
   assign w_b[1] = b1;
   assign w_b[2] = b2;
   assign w_b[3] = b3;

   assign in_ready  = (r_state == StAcc) && !reset;
   assign out_valid = (r_state == StHold);
   assign w_accept  = in_valid && in_ready;
   // The MAX_TERMS-th accepted term closes the burst even without in_last.
   assign w_last    = in_last || (r_cnt == 8'(MAX_TERMS - 1));
   assign w_done    = r_v2 && r_l2;
   assign w_clear   = out_valid && out_ready;
   assign err       = r_err;
   assign y0        = w_acc[0];
   assign y1        = w_acc[1];
   assign y2        = w_acc[2];
   assign y3        = w_acc[3];

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StAcc:   if (w_accept && w_last) w_state_d = StDrain;
         StDrain: if (w_done) w_state_d = StHold;
         StHold:  if (out_ready) w_state_d = StAcc;
         default: w_state_d = StAcc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StAcc;
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_l1    <= 1'b0;
         r_l2    <= 1'b0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_v1    <= w_accept;
         r_l1    <= w_accept && w_last;
         r_v2    <= r_v1;
         r_l2    <= r_v1 && r_l1;
         if (w_clear) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_accept && (|w_oor)) begin
            r_err <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_ch
      localparam int unsigned MI = (g == 0) ? MOD_1 : (g == 1) ? MOD_2 :
                                   (g == 2) ? MOD_3 : MOD_4;
      localparam logic [MAX_MOD:0] M = (MAX_MOD + 1)'(MI);

      logic [PW-1:0]      r_p;
      logic [MAX_MOD-1:0] r_r, r_acc, w_red;
      logic [MAX_MOD:0]   w_sum;

      if (g == 0) begin : g_trunc
         assign w_red = MAX_MOD'(MOD_1_K'(r_p));
      end else begin : g_rem
         assign w_red = MAX_MOD'(r_p % PW'(MI));
      end

      assign w_sum    = {1'b0, r_acc} + {1'b0, r_r};
      assign w_oor[g] = ({1'b0, w_a[g]} >= M) || ({1'b0, w_b[g]} >= M);
      assign w_acc[g] = r_acc;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_p   <= '0;
            r_r   <= '0;
            r_acc <= '0;
         end else begin
            if (w_accept) begin
               r_p <= PW'(w_a[g]) * PW'(w_b[g]);
            end
            if (r_v1) begin
               r_r <= w_red;
            end
            // Both addends are below M, so one conditional subtract keeps acc in range.
            if (r_v2) begin
               r_acc <= (w_sum >= M) ? MAX_MOD'(w_sum - M) : MAX_MOD'(w_sum);
            end else if (w_clear) begin
               r_acc <= '0;
            end
         end
      end
   end

endmodule
